fft_bf_sched: RTL and testbench
===============================

# fft_bf_sched

Butterfly scheduler for the 64-point in-place radix-2 DIF FFT. It sequences the single shared `bf32` butterfly across 6 stages × 32 butterflies. For each butterfly it issues a read address pair and a twiddle index, then re-issues the same address pair as a delayed write-back once the memory and butterfly pipeline latency has elapsed. It sits between the top-level start/done control and the dual-port working memory plus twiddle ROM. It carries no sample data.

## Interface
Parameters:
- `LAT`, 2: cycles from `rd_en` to the matching `wr_en` (memory read plus butterfly register); legal range 1..8.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request one full 64-point transform; sampled only in IDLE.
- `busy`, out, 1: high from the first ISSUE cycle through the last DRAIN cycle.
- `done`, out, 1: one-cycle pulse when the transform is complete.
- `stage`, out, 3: current stage, 0..5.
- `rd_en`, out, 1: read-pair valid.
- `rd_addr0`, out, 6: upper butterfly input address.
- `rd_addr1`, out, 6: lower butterfly input address.
- `tw_idx`, out, 5: twiddle ROM index, aligned with `rd_en`.
- `wr_en`, out, 1: write-back pair valid.
- `wr_addr0`, out, 6: write-back address for `data_out_0`.
- `wr_addr1`, out, 6: write-back address for `data_out_1`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 → ISSUE. Set s=0, b=0.
- ISSUE: one butterfly per cycle, `rd_en`=1.
  - b=31 → DRAIN with a drain counter loaded to LAT.
  - Otherwise b increments.
- DRAIN: `rd_en`=0 for exactly LAT cycles.
  - If s<5: → ISSUE with s+1, b=0.
  - If s=5: → DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then → IDLE.
- Address generation, for stage s and butterfly b (0..31):
  - span = 32>>s
  - pos = b mod span
  - grp = b / span
  - `rd_addr0` = grp·2·span + pos
  - `rd_addr1` = `rd_addr0` + span
  - `tw_idx` = pos << s, truncated to 5 bits
- All products are shifts and masks; no multipliers.
- Write-back path: {`rd_en`, `rd_addr0`, `rd_addr1`} delayed exactly LAT cycles gives {`wr_en`, `wr_addr0`, `wr_addr1`}. The write-back is in place.
- Stage hazard: DRAIN guarantees the last write of stage s occurs before the first read of stage s+1.
- `start` in ISSUE, DRAIN or DONE is ignored. It is not queued.
- Reset, including mid-transform: FSM returns to IDLE and the delay line is cleared, so no `wr_en` is emitted after reset.
- Reset value of every output is 0.

## Timing
- `start` sampled high at cycle T → first `rd_en` at T+1 with s=0, b=0.
- `rd_en` is high for 32 consecutive cycles per stage, followed by LAT idle cycles.
- A read at cycle c produces a write at c+LAT, with identical addresses.
- The first read of the next stage occurs at (last read of the stage)+LAT+1.
- `done` pulses at T+1+6·(32+LAT). With LAT=2 this is T+205.
- `busy` is high T+1 … T+6·(32+LAT). It is low during the `done` cycle.
- The earliest next accepted `start` is the cycle after `done`.
- `stage` updates in the same cycle as the first read of the new stage. It holds its value during DRAIN and returns to 0 in IDLE.

## Structure
- `fft_pkg` holds:
  - N=64, LOG2N=6, NBF=32
  - address width 6, twiddle width 5
  - FSM state enum
- Shared by the datapath top and the twiddle ROM.
- One sub-module, `fft_wb_delay`: a LAT-deep shift register for {`en`, `addr0`, `addr1`}, asynchronously cleared.

## Test plan
- Reset, then `start` at T → `rd_en` rises at T+1 with (`rd_addr0`, `rd_addr1`, `tw_idx`) = (0, 32, 0). At T+6 (b=5) the values are (5, 37, 5). `wr_en` first rises at T+3 with addresses 0/32 (LAT=2).
- Address sweep checked against a reference model:
  - s=1, b=16 → (32, 48, 0)
  - s=2, b=9 → (17, 25, 4)
  - s=5, b=3 → (6, 7, 0)
  - Every address 0..63 is read exactly once per stage.
- Stage turnover, LAT=2: the last `wr_en` of stage 0 falls in the final DRAIN cycle, and the first stage-1 `rd_en` follows on the next cycle. `done` pulses exactly at T+205. `busy` totals 204 cycles.
- `start` held high throughout → exactly one transform runs. A second transform starts at done+1 (IDLE), i.e. the second `rd_en` burst begins 2 cycles after `done`.
- `rst_n` dropped at stage 3, b=10 → all outputs are 0 immediately (asynchronously). After release there is no `wr_en` and no `done` until a new `start`.
- LAT=5 build → `wr_en` trails `rd_en` by 5 cycles, and `done` pulses at T+1+6·37.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, FSM state and butterfly address generation
// for the 64-point in-place radix-2 DIF FFT.
package fft_pkg;

    localparam int N     = 64;
    localparam int LOG2N = 6;
    localparam int NBF   = N / 2;
    localparam int AW    = $clog2(N);
    localparam int TWW   = $clog2(NBF);
    localparam int BW    = $clog2(NBF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fsm_state_t;

    typedef struct packed {
        logic [AW-1:0]  a0;
        logic [AW-1:0]  a1;
        logic [TWW-1:0] tw;
    } bf_addr_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
    } wb_t;

    // mask = span-1, so b & ~mask is grp*span and doubling it skips the lower halves
    function automatic bf_addr_t bf_addr(input logic [2:0] s,
                                         input logic [BW-1:0] b);
        logic [BW-1:0] mask;
        logic [BW-1:0] pos;
        bf_addr_t      r;
        mask = BW'(NBF - 1) >> s;
        pos  = b & mask;
        r.a0 = {b & ~mask, 1'b0} | {1'b0, pos};
        r.a1 = r.a0 | ({1'b0, mask} + 6'd1);
        r.tw = pos << s;
        return r;
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: LAT-deep shift register carrying the read pair
// forward to become the in-place write-back pair.
module fft_wb_delay
    import fft_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  wb_t  d,
    output wb_t  q
);

    wb_t pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LAT-1];

endmodule

// File: rtl/fft_bf_sched.sv
// fft_bf_sched: sequences one shared butterfly over 6 stages x 32
// butterflies, issuing read pairs, twiddles and delayed write-backs.
module fft_bf_sched
    import fft_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [2:0]     stage,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr0,
    output logic [AW-1:0]  rd_addr1,
    output logic [TWW-1:0] tw_idx,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr0,
    output logic [AW-1:0]  wr_addr1
);

    fsm_state_t    state;
    logic [2:0]    s_q;
    logic [BW-1:0] b_q;
    logic [3:0]    drain_q;
    bf_addr_t      rd_q;
    bf_addr_t      nxt_b;
    bf_addr_t      nxt_s;
    wb_t           wb_d;
    wb_t           wb_q;

    always_comb begin
        nxt_b = bf_addr(s_q, b_q + 5'd1);
        nxt_s = bf_addr(s_q + 3'd1, '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            drain_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_q    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ISSUE;
                        s_q   <= '0;
                        b_q   <= '0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        rd_q  <= bf_addr(3'd0, '0);
                    end
                end
                ST_ISSUE: begin
                    if (b_q == BW'(NBF - 1)) begin
                        state   <= ST_DRAIN;
                        drain_q <= 4'(LAT);
                        rd_en   <= 1'b0;
                    end else begin
                        b_q  <= b_q + 5'd1;
                        rd_q <= nxt_b;
                    end
                end
                // hold reads off until the last write of this stage lands
                ST_DRAIN: begin
                    if (drain_q == 4'd1) begin
                        if (s_q == 3'(LOG2N - 1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                            s_q   <= s_q + 3'd1;
                            b_q   <= '0;
                            rd_en <= 1'b1;
                            rd_q  <= nxt_s;
                        end
                    end else begin
                        drain_q <= drain_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    s_q   <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stage    = s_q;
    assign rd_addr0 = rd_q.a0;
    assign rd_addr1 = rd_q.a1;
    assign tw_idx   = rd_q.tw;

    assign wb_d = '{en: rd_en, a0: rd_q.a0, a1: rd_q.a1};

    fft_wb_delay #(
        .LAT (LAT)
    ) u_wb_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wb_d),
        .q     (wb_q)
    );

    assign wr_en    = wb_q.en;
    assign wr_addr0 = wb_q.a0;
    assign wr_addr1 = wb_q.a1;

endmodule

// File: tb/tb_fft_bf_sched.sv
// tb_fft_bf_sched: scoreboard plus vector table for the FFT butterfly
// scheduler, with a second LAT=5 instance for latency scaling.
module tb_fft_bf_sched;
    import fft_pkg::*;

    localparam int L2 = 2;
    localparam int L5 = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    logic busy, done, rd_en, wr_en;
    logic [2:0] stage;
    logic [5:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [4:0] tw_idx;

    logic busy_5, done_5, rd_en_5, wr_en_5;
    logic [2:0] stage_5;
    logic [5:0] rd_addr0_5, rd_addr1_5, wr_addr0_5, wr_addr1_5;
    logic [4:0] tw_idx_5;

    fft_bf_sched #(.LAT(L2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .tw_idx(tw_idx), .wr_en(wr_en),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    fft_bf_sched #(.LAT(L5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy_5), .done(done_5), .stage(stage_5),
        .rd_en(rd_en_5), .rd_addr0(rd_addr0_5), .rd_addr1(rd_addr1_5),
        .tw_idx(tw_idx_5), .wr_en(wr_en_5),
        .wr_addr0(wr_addr0_5), .wr_addr1(wr_addr1_5)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int cyc; int s; int b; int a0; int a1; int tw; } rd_t;
    typedef struct { int cyc; int a0; int a1; } wr_t;
    typedef struct { int s; int b; int a0; int a1; int tw; } vec_t;

    rd_t rdq[$];
    wr_t wrq[$];
    logic [12:0] rh[$];

    int free_at = 0;
    int done_at = -1;
    int busy_lo = -1;
    int busy_hi = -2;

    bit cap_on = 1'b0;
    int cap_cyc [192];
    int cap_a0 [192];
    int cap_a1 [192];
    int cap_tw [192];
    int cov [6][64];
    int bcnt = 0;
    int last_done = -1;
    int w_first = -1, w_a0 = -1, w_a1 = -1;
    int r5_first = -1, w5_first = -1, s5_first = -1, d5_cyc = -1;

    task automatic chk(input string nm, input int act, input int ex);
        checks++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d cyc=%0d", nm, act, ex, cyc);
        end
    endtask

    // reference model: on an accepted start, queue every read and write
    always @(posedge clk) begin
        rd_t mr;
        wr_t mw;
        int sp, pos, grp;
        if (!rst_n) begin
            rdq.delete();
            wrq.delete();
            free_at = cyc + 1;
            done_at = -1;
            busy_lo = -1;
            busy_hi = -2;
        end else if (start && cyc >= free_at) begin
            for (int s = 0; s < 6; s++) begin
                for (int b = 0; b < 32; b++) begin
                    sp = 32 >> s;
                    pos = b % sp;
                    grp = b / sp;
                    mr.cyc = cyc + 1 + s * (32 + L2) + b;
                    mr.s = s;
                    mr.b = b;
                    mr.a0 = grp * 2 * sp + pos;
                    mr.a1 = mr.a0 + sp;
                    mr.tw = (pos << s) % 32;
                    rdq.push_back(mr);
                    mw.cyc = mr.cyc + L2;
                    mw.a0 = mr.a0;
                    mw.a1 = mr.a1;
                    wrq.push_back(mw);
                end
            end
            busy_lo = cyc + 1;
            busy_hi = cyc + 6 * (32 + L2);
            done_at = cyc + 1 + 6 * (32 + L2);
            free_at = done_at + 1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit er, ew;
        rd_t r;
        wr_t w;
        int idx;
        if (!rst_n) begin
            chk("rst_out", |{busy, done, stage, rd_en, rd_addr0, rd_addr1,
                             tw_idx, wr_en, wr_addr0, wr_addr1}, 0);
            chk("rst_out5", |{busy_5, done_5, stage_5, rd_en_5, rd_addr0_5,
                              rd_addr1_5, tw_idx_5, wr_en_5, wr_addr0_5,
                              wr_addr1_5}, 0);
            rh.delete();
        end else begin
            er = rdq.size() > 0 && rdq[0].cyc == cyc;
            chk("rd_en", rd_en, er);
            if (er) begin
                r = rdq.pop_front();
                if (rd_en) begin
                    chk("rd_addr0", rd_addr0, r.a0);
                    chk("rd_addr1", rd_addr1, r.a1);
                    chk("tw_idx", tw_idx, r.tw);
                    chk("stage", stage, r.s);
                    if (cap_on) begin
                        idx = r.s * 32 + r.b;
                        cap_cyc[idx] = cyc;
                        cap_a0[idx] = rd_addr0;
                        cap_a1[idx] = rd_addr1;
                        cap_tw[idx] = tw_idx;
                        cov[r.s][rd_addr0]++;
                        cov[r.s][rd_addr1]++;
                    end
                end
            end
            ew = wrq.size() > 0 && wrq[0].cyc == cyc;
            chk("wr_en", wr_en, ew);
            if (ew) begin
                w = wrq.pop_front();
                if (wr_en) begin
                    chk("wr_addr0", wr_addr0, w.a0);
                    chk("wr_addr1", wr_addr1, w.a1);
                end
            end
            chk("done", done, cyc == done_at);
            chk("busy", busy, cyc >= busy_lo && cyc <= busy_hi);
            if (busy) bcnt++;
            if (done) last_done = cyc;
            if (wr_en && w_first < 0) begin
                w_first = cyc;
                w_a0 = wr_addr0;
                w_a1 = wr_addr1;
            end
            if (rd_en_5 && r5_first < 0) r5_first = cyc;
            if (wr_en_5 && w5_first < 0) w5_first = cyc;
            if (rd_en_5 && stage_5 == 3'd1 && s5_first < 0) s5_first = cyc;
            if (done_5 && d5_cyc < 0) d5_cyc = cyc;
            rh.push_front({rd_en_5, rd_addr0_5, rd_addr1_5});
            if (rh.size() > L5) begin
                chk("wr5_delay", {wr_en_5, wr_addr0_5, wr_addr1_5}, rh[L5]);
                void'(rh.pop_back());
            end
        end
    end

    initial begin
        vec_t tbl [12];
        int t0, ts, t3, t4, dd, rr, n, bad;

        tbl[0]  = '{0, 0, 0, 32, 0};
        tbl[1]  = '{0, 5, 5, 37, 5};
        tbl[2]  = '{0, 31, 31, 63, 31};
        tbl[3]  = '{1, 16, 32, 48, 0};
        tbl[4]  = '{1, 31, 47, 63, 30};
        tbl[5]  = '{2, 9, 17, 25, 4};
        tbl[6]  = '{2, 6, 6, 14, 24};
        tbl[7]  = '{3, 10, 18, 22, 16};
        tbl[8]  = '{3, 31, 59, 63, 24};
        tbl[9]  = '{4, 7, 13, 15, 16};
        tbl[10] = '{5, 3, 6, 7, 0};
        tbl[11] = '{5, 31, 62, 63, 0};

        repeat (3) @(negedge clk);
        chk("rst_rd_addr1", rd_addr1, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // single transform: full sweep, timing and coverage
        for (int s = 0; s < 6; s++)
            for (int a = 0; a < 64; a++) cov[s][a] = 0;
        cap_on = 1'b1;
        bcnt = 0;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (232) @(negedge clk);
        cap_on = 1'b0;

        for (int i = 0; i < 12; i++) begin
            n = tbl[i].s * 32 + tbl[i].b;
            chk($sformatf("vec%0d_a0", i), cap_a0[n], tbl[i].a0);
            chk($sformatf("vec%0d_a1", i), cap_a1[n], tbl[i].a1);
            chk($sformatf("vec%0d_tw", i), cap_tw[n], tbl[i].tw);
        end
        for (int s = 0; s < 6; s++) begin
            bad = 0;
            for (int a = 0; a < 64; a++) if (cov[s][a] != 1) bad++;
            chk($sformatf("cover_stage%0d", s), bad, 0);
        end
        chk("first_rd_cyc", cap_cyc[0], t0 + 1);
        chk("b5_rd_cyc", cap_cyc[5], t0 + 6);
        chk("s1_first_rd", cap_cyc[32], t0 + 1 + 34);
        chk("s0_last_rd", cap_cyc[31], t0 + 32);
        chk("first_wr_cyc", w_first, t0 + 3);
        chk("first_wr_a0", w_a0, 0);
        chk("first_wr_a1", w_a1, 32);
        chk("done_cyc", last_done, t0 + 205);
        chk("busy_total", bcnt, 204);
        chk("lat5_first_rd", r5_first, t0 + 1);
        chk("lat5_first_wr", w5_first, t0 + 6);
        chk("lat5_s1_rd", s5_first, t0 + 1 + 37);
        chk("lat5_done", d5_cyc, t0 + 1 + 6 * 37);

        // start held high: one transform, then restart right after done
        @(negedge clk);
        ts = cyc;
        start = 1'b1;
        dd = -1;
        for (int i = 0; i < 260 && dd < 0; i++) begin
            @(negedge clk);
            if (done) dd = cyc;
        end
        chk("hold_done_cyc", dd, ts + 205);
        rr = -1;
        for (int i = 0; i < 6 && rr < 0; i++) begin
            @(negedge clk);
            if (rd_en) rr = cyc;
        end
        chk("hold_restart", rr, dd + 2);
        start = 1'b0;
        repeat (220) @(negedge clk);

        // asynchronous reset in stage 3, b=10
        @(negedge clk);
        t3 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (112) @(negedge clk);
        chk("mid_stage", stage, 3);
        chk("mid_rd_addr0", rd_addr0, 18);
        chk("mid_cyc", cyc, t3 + 113);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", |{busy, done, stage, rd_en, rd_addr0, rd_addr1,
                           tw_idx, wr_en, wr_addr0, wr_addr1}, 0);
        chk("async_rst5", |{busy_5, rd_en_5, wr_en_5, stage_5}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (wr_en || done || rd_en) n++;
        end
        chk("post_rst_quiet", n, 0);

        // restart after reset
        @(negedge clk);
        t4 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (210) @(negedge clk);
        chk("restart_done", last_done, t4 + 205);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
